seg7_capture: RTL and testbench

- Receive-side counterpart of the multiplexed 4-digit 7-segment driver: observes the SEGMENT/DIG scan and reconstructs the four displayed characters as ASCII bytes DATA1..DATA4.
- Used for display loopback checking and for monitoring an external panel.
- Inputs are synchronised, allowed to settle after each digit switch, sampled, decoded, and confirmed over repeated scans before being published.

---
 rtl/seg7_capture.sv | 239 +++++++++++++++++++++++
 tb/tb_seg7_capture.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_capture.sv
// seg7_capture
//   Receive side of a multiplexed 4-digit 7-segment display. Watches the
//   active-low SEGMENT/DIG scan, waits for each newly enabled digit to
//   settle, samples and decodes its segment pattern to ASCII, and publishes
//   a digit only after CONFIRM consecutive identical samples.
//
// Ports
//   CLK          system clock, rising edge
//   RST_N        asynchronous active-low reset
//   SEGMENT[7:0] active-low segments {dp,g,f,e,d,c,b,a}
//   DIG[3:0]     active-low digit enables, DIG[0] -> DATA1
//   DATA1..DATA4 decoded ASCII per digit (blank = 8'h20)
//   DP[3:0]      decimal point per digit, DP[0] -> DATA1
//   CHANGED      one-cycle pulse when any published DATAn/DP value changes
//   STALE        no sample taken for TIMEOUT_CYC cycles
//   ERR          sticky, more than one DIG bit seen low
//
// Build option
//   SEG7_CAPTURE_DP_EN : capture the decimal point with each digit. When not
//   defined SEGMENT[7] is ignored and DP is tied low.
//
// state  | meaning
// IDLE   | no single digit enabled (all high or multi-hot)
// SETTLE | one digit enabled, waiting SETTLE_CYC cycles
// SAMPLE | one-cycle sample/decode/confirm of the latched digit
// HOLD   | sample done, waiting for DIG to move off this digit
module seg7_capture #(
  parameter int SETTLE_CYC  = 4,
  parameter int CONFIRM     = 2,
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [7:0] SEGMENT,
  input  logic [3:0] DIG,
  output logic [7:0] DATA1,
  output logic [7:0] DATA2,
  output logic [7:0] DATA3,
  output logic [7:0] DATA4,
  output logic [3:0] DP,
  output logic       CHANGED,
  output logic       STALE,
  output logic       ERR
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETTLE = 2'd1;
  localparam logic [1:0] SAMPLE = 2'd2;
  localparam logic [1:0] HOLD   = 2'd3;

  localparam int              TW          = $clog2(TIMEOUT_CYC + 1);
  localparam logic [7:0]      SETTLE_LAST = 8'(SETTLE_CYC - 1);
  localparam logic [3:0]      CONF_MAX    = 4'(CONFIRM);
  localparam logic [TW-1:0]   TMO_MAX     = TW'(TIMEOUT_CYC);

  logic [7:0]    seg_m, seg_s;
  logic [3:0]    dig_m, dig_s;
  logic [1:0]    state;
  logic [7:0]    settle_cnt;
  logic [1:0]    dig_idx;
  logic [TW-1:0] tmo_cnt;
  logic [7:0]    cand_chr [4];
  logic [3:0]    cand_dp;
  logic [3:0]    cand_cnt [4];
  logic [7:0]    data_q [4];
  logic [3:0]    dp_q;
  logic          changed_q;
  logic          err_q;

  logic [3:0]    dig_low;
  logic          any_low, one_hot, multi_hot;
  logic [1:0]    new_idx;
  logic [7:0]    samp_chr;
  logic          samp_dp;
  logic          samp_match;
  logic [3:0]    samp_cnt;
  logic          publish;

  function automatic logic [7:0] decode(input logic [6:0] p);
    case (p)
      7'h3F: decode = "0";
      7'h06: decode = "1";
      7'h5B: decode = "2";
      7'h4F: decode = "3";
      7'h66: decode = "4";
      7'h6D: decode = "5";
      7'h7D: decode = "6";
      7'h07: decode = "7";
      7'h7F: decode = "8";
      7'h6F: decode = "9";
      7'h77: decode = "A";
      7'h7C: decode = "b";
      7'h39: decode = "C";
      7'h5E: decode = "d";
      7'h79: decode = "E";
      7'h71: decode = "F";
      7'h40: decode = "-";
      7'h00: decode = " ";
      default: decode = "?";
    endcase
  endfunction

  // Synchronisers reset to the inactive level so reset never looks multi-hot.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      seg_m <= 8'hFF;
      seg_s <= 8'hFF;
      dig_m <= 4'hF;
      dig_s <= 4'hF;
    end else begin
      seg_m <= SEGMENT;
      seg_s <= seg_m;
      dig_m <= DIG;
      dig_s <= dig_m;
    end
  end

  assign dig_low   = ~dig_s;
  assign any_low   = |dig_low;
  assign one_hot   = any_low && ((dig_low & (dig_low - 4'd1)) == 4'd0);
  assign multi_hot = any_low && !one_hot;

  always_comb begin
    new_idx = 2'd0;
    case (dig_low)
      4'b0010: new_idx = 2'd1;
      4'b0100: new_idx = 2'd2;
      4'b1000: new_idx = 2'd3;
      default: new_idx = 2'd0;
    endcase
  end

`ifdef SEG7_CAPTURE_DP_EN
  assign samp_dp = ~seg_s[7];
  assign DP      = dp_q;
`else
  logic unused_dp_bit;
  assign unused_dp_bit = seg_s[7];
  assign samp_dp       = 1'b0;
  assign DP            = 4'b0000;
`endif

  assign samp_chr   = decode(~seg_s[6:0]);
  assign samp_match = (samp_chr == cand_chr[dig_idx]) && (samp_dp == cand_dp[dig_idx]);
  assign samp_cnt   = !samp_match                      ? 4'd1 :
                      (cand_cnt[dig_idx] >= CONF_MAX)  ? CONF_MAX :
                                                         cand_cnt[dig_idx] + 4'd1;
  assign publish    = (state == SAMPLE) && (samp_cnt == CONF_MAX) &&
                      ({samp_chr, samp_dp} != {data_q[dig_idx], dp_q[dig_idx]});

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state      <= IDLE;
      settle_cnt <= 8'd0;
      dig_idx    <= 2'd0;
    end else begin
      case (state)
        IDLE: begin
          if (one_hot) begin
            state      <= SETTLE;
            dig_idx    <= new_idx;
            settle_cnt <= 8'd0;
          end
        end
        SETTLE: begin
          if (!one_hot) begin
            state <= IDLE;
          end else if (new_idx != dig_idx) begin
            dig_idx    <= new_idx;
            settle_cnt <= 8'd0;
          end else if (settle_cnt == SETTLE_LAST) begin
            state <= SAMPLE;
          end else begin
            settle_cnt <= settle_cnt + 8'd1;
          end
        end
        SAMPLE: state <= HOLD;
        default: begin
          if (!one_hot) begin
            state <= IDLE;
          end else if (new_idx != dig_idx) begin
            state      <= SETTLE;
            dig_idx    <= new_idx;
            settle_cnt <= 8'd0;
          end
        end
      endcase
    end
  end

  // Candidates clear to 8'h00, which no pattern decodes to, so the first
  // sample of every digit always starts a fresh confirm run.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < 4; i++) begin
        cand_chr[i] <= 8'h00;
        cand_cnt[i] <= 4'd0;
        data_q[i]   <= 8'h20;
      end
      cand_dp   <= 4'b0000;
      dp_q      <= 4'b0000;
      changed_q <= 1'b0;
    end else begin
      if (state == SAMPLE) begin
        cand_chr[dig_idx] <= samp_chr;
        cand_dp[dig_idx]  <= samp_dp;
        cand_cnt[dig_idx] <= samp_cnt;
        if (publish) begin
          data_q[dig_idx] <= samp_chr;
          dp_q[dig_idx]   <= samp_dp;
        end
      end
      changed_q <= publish;
    end
  end

  // A sample clears the timeout in the same edge it would otherwise expire.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      tmo_cnt <= '0;
      err_q   <= 1'b0;
    end else begin
      if (state == SAMPLE)
        tmo_cnt <= '0;
      else if (tmo_cnt != TMO_MAX)
        tmo_cnt <= tmo_cnt + TW'(1);
      err_q <= err_q | multi_hot;
    end
  end

  assign DATA1   = data_q[0];
  assign DATA2   = data_q[1];
  assign DATA3   = data_q[2];
  assign DATA4   = data_q[3];
  assign CHANGED = changed_q;
  assign STALE   = (tmo_cnt == TMO_MAX);
  assign ERR     = err_q;

endmodule

// File: tb/tb_seg7_capture.sv
module tb_seg7_capture;
  localparam int SETTLE_CYC  = 4;
  localparam int CONFIRM     = 2;
  localparam int TIMEOUT_CYC = 1000;

`ifdef SEG7_CAPTURE_DP_EN
  localparam bit DP_EN = 1'b1;
`else
  localparam bit DP_EN = 1'b0;
`endif

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic [7:0] SEGMENT = 8'hFF;
  logic [3:0] DIG = 4'hF;
  logic [7:0] DATA1, DATA2, DATA3, DATA4;
  logic [3:0] DP;
  logic       CHANGED, STALE, ERR;

  int total = 0;
  int bad   = 0;
  int pulses = 0;
  bit saw38 = 1'b0;

  always #5 CLK = ~CLK;

  seg7_capture #(
    .SETTLE_CYC (SETTLE_CYC),
    .CONFIRM    (CONFIRM),
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .CLK    (CLK),
    .RST_N  (RST_N),
    .SEGMENT(SEGMENT),
    .DIG    (DIG),
    .DATA1  (DATA1),
    .DATA2  (DATA2),
    .DATA3  (DATA3),
    .DATA4  (DATA4),
    .DP     (DP),
    .CHANGED(CHANGED),
    .STALE  (STALE),
    .ERR    (ERR)
  );

  // Pattern table for the display font.
  localparam logic [6:0] PATS [18] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D,
                                       7'h7D, 7'h07, 7'h7F, 7'h6F, 7'h77, 7'h7C,
                                       7'h39, 7'h5E, 7'h79, 7'h71, 7'h40, 7'h00};
  localparam logic [7:0] CHRS [18] = '{"0", "1", "2", "3", "4", "5", "6", "7", "8",
                                       "9", "A", "b", "C", "d", "E", "F", "-", " "};

  function automatic logic [7:0] char_of(input logic [6:0] p);
    logic [7:0] c = "?";
    for (int i = 0; i < 18; i++)
      if (PATS[i] == p) c = CHRS[i];
    return c;
  endfunction

  function automatic int low_count(input logic [3:0] d);
    int n = 0;
    for (int i = 0; i < 4; i++)
      if (!d[i]) n++;
    return n;
  endfunction

  function automatic int low_pos(input logic [3:0] d);
    int k = 0;
    for (int i = 0; i < 4; i++)
      if (!d[i]) k = i;
    return k;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h want %0h", name, $time, act, exp);
    end
  endtask

  // Behavioural model: inputs are seen two cycles late; a digit is sampled once,
  // when it has been continuously visible for SETTLE_CYC+2 cycles.
  logic [3:0] m_s1d, m_s2d;
  logic [7:0] m_s1s, m_s2s;
  int         m_run;
  logic [7:0] m_cand [4];
  logic       m_cdp  [4];
  int         m_ccnt [4];
  logic [7:0] m_data [4];
  logic [3:0] m_dp;
  logic       m_chg, m_err;
  int         m_since;
  int         md;
  logic [7:0] mch;
  logic       mdpv;

  task automatic m_reset();
    m_s1d = 4'hF; m_s2d = 4'hF; m_s1s = 8'hFF; m_s2s = 8'hFF; m_run = 0;
    for (int i = 0; i < 4; i++) begin
      m_cand[i] = 8'h00; m_cdp[i] = 1'b0; m_ccnt[i] = 0; m_data[i] = 8'h20;
    end
    m_dp = 4'b0000; m_chg = 1'b0; m_err = 1'b0; m_since = 0;
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge CLK or negedge RST_N);
      if (!RST_N) begin
        m_reset();
      end else begin
        m_chg = 1'b0;
        if (low_count(m_s2d) == 1 && m_run == SETTLE_CYC + 2) begin
          md   = low_pos(m_s2d);
          mch  = char_of(~m_s2s[6:0]);
          mdpv = DP_EN ? ~m_s2s[7] : 1'b0;
          if (mch == m_cand[md] && mdpv == m_cdp[md])
            m_ccnt[md] = (m_ccnt[md] < CONFIRM) ? m_ccnt[md] + 1 : CONFIRM;
          else begin
            m_cand[md] = mch; m_cdp[md] = mdpv; m_ccnt[md] = 1;
          end
          if (m_ccnt[md] == CONFIRM && (mch != m_data[md] || mdpv != m_dp[md])) begin
            m_data[md] = mch; m_dp[md] = mdpv; m_chg = 1'b1;
          end
          m_since = 0;
        end else if (m_since < TIMEOUT_CYC) begin
          m_since++;
        end
        if (low_count(m_s2d) >= 2) m_err = 1'b1;
        m_run = (m_s1d == m_s2d) ? m_run + 1 : 1;
        m_s2d = m_s1d; m_s2s = m_s1s;
        m_s1d = DIG;   m_s1s = SEGMENT;
      end
    end
  end

  initial forever begin
    @(negedge CLK);
    if (RST_N) begin
      check("cycle", {25'd0, DATA1, DATA2, DATA3, DATA4, DP, CHANGED, STALE, ERR},
            {25'd0, m_data[0], m_data[1], m_data[2], m_data[3], m_dp, m_chg,
             (m_since >= TIMEOUT_CYC), m_err});
      if (CHANGED) pulses++;
      if (DATA1 == 8'h38) saw38 = 1'b1;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic show_digit(input int d, input logic [6:0] p, input logic dp, input int dwell);
    DIG     = ~(4'b0001 << d);
    SEGMENT = ~{dp, p};
    step(dwell);
  endtask

  task automatic scan(input logic [6:0] p0, input logic [6:0] p1, input logic [6:0] p2,
                      input logic [6:0] p3, input logic [3:0] dps);
    show_digit(0, p0, dps[0], 20);
    show_digit(1, p1, dps[1], 20);
    show_digit(2, p2, dps[2], 20);
    show_digit(3, p3, dps[3], 20);
  endtask

  initial begin
    // reset values
    step(3);
    check("rst_data", {DATA1, DATA2, DATA3, DATA4}, 32'h20202020);
    check("rst_flags", {DP, CHANGED, STALE, ERR}, 7'b0);
    RST_N = 1'b1;
    step(2);

    // basic capture, two scans of "1234"
    pulses = 0;
    scan(7'h06, 7'h5B, 7'h4F, 7'h66, 4'b0000);
    DIG = 4'b1110; SEGMENT = ~{1'b0, 7'h06};
    step(7);
    check("lat_before", DATA1, 8'h20);
    step(1);
    check("lat_edge7", DATA1, 8'h31);
    step(12);
    show_digit(1, 7'h5B, 1'b0, 20);
    show_digit(2, 7'h4F, 1'b0, 20);
    show_digit(3, 7'h66, 1'b0, 20);
    check("basic_data", {DATA1, DATA2, DATA3, DATA4}, 32'h31323334);
    check("basic_pulses", pulses, 4);

    // glitch rejection on digit 1, unknown pattern on digit 2
    pulses = 0;
    saw38  = 1'b0;
    scan(7'h7F, 7'h49, 7'h4F, 7'h66, 4'b0000);
    scan(7'h6D, 7'h49, 7'h4F, 7'h66, 4'b0000);
    check("glitch_first5", DATA1, 8'h31);
    scan(7'h6D, 7'h49, 7'h4F, 7'h66, 4'b0000);
    check("glitch_second5", DATA1, 8'h35);
    check("glitch_no38", saw38, 0);
    check("unknown_q", DATA2, 8'h3F);
    check("glitch_pulses", pulses, 2);

    // reset mid-scan while in SETTLE
    DIG = 4'b1110; SEGMENT = ~{1'b0, 7'h06};
    step(4);
    RST_N = 1'b0;
    #1;
    check("midrst_data", {DATA1, DATA2, DATA3, DATA4}, 32'h20202020);
    check("midrst_chg", CHANGED, 0);
    SEGMENT = 8'hFF;
    step(2);
    RST_N = 1'b1;

    // blank pattern after reset: value unchanged, no pulse
    pulses = 0;
    step(19);
    show_digit(1, 7'h00, 1'b0, 20);
    show_digit(2, 7'h00, 1'b0, 20);
    show_digit(3, 7'h00, 1'b0, 20);
    scan(7'h00, 7'h00, 7'h00, 7'h00, 4'b0000);
    check("blank_data", {DATA1, DATA2, DATA3, DATA4}, 32'h20202020);
    check("blank_pulses", pulses, 0);

    // decimal point on digit 3
    pulses = 0;
    scan(7'h00, 7'h00, 7'h07, 7'h00, 4'b0100);
    scan(7'h00, 7'h00, 7'h07, 7'h00, 4'b0100);
    check("dp_data3", DATA3, 8'h37);
    check("dp_on", DP, DP_EN ? 4'b0100 : 4'b0000);
    check("dp_on_pulses", pulses, 1);
    pulses = 0;
    scan(7'h00, 7'h00, 7'h07, 7'h00, 4'b0000);
    scan(7'h00, 7'h00, 7'h07, 7'h00, 4'b0000);
    check("dp_off", DP, 4'b0000);
    check("dp_off_pulses", pulses, DP_EN ? 1 : 0);

    // multi-hot then timeout then resume
    pulses = 0;
    DIG = 4'b1100; SEGMENT = ~{1'b0, 7'h7F};
    step(5);
    check("multi_err", ERR, 1);
    check("multi_pulses", pulses, 0);
    check("multi_data3", DATA3, 8'h37);
    DIG = 4'hF; SEGMENT = 8'hFF;
    step(TIMEOUT_CYC);
    check("stale_set", STALE, 1);
    DIG = 4'b1110; SEGMENT = ~{1'b0, 7'h06};
    step(7);
    check("stale_in_sample", STALE, 1);
    step(1);
    check("stale_cleared", STALE, 0);
    check("err_sticky", ERR, 1);
    step(12);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
